// File: rtl/mac_dot_seq_pkg.sv
// Shared types and constants for the mac_dot_seq dot-product sequencer.
package mac_dot_seq_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 2 * DATA_W_DEF;
  localparam int LEN_W_DEF  = 8;

  // Saturation bounds for the default accumulator width.
  localparam logic signed [ACC_W_DEF-1:0] ACC_SAT_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
  localparam logic signed [ACC_W_DEF-1:0] ACC_SAT_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mac_dot_seq_if.sv
// Command, operand-stream and result handshake bundle for mac_dot_seq.
interface mac_dot_seq_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int LEN_W  = 8
);

  logic              start;
  logic [LEN_W-1:0]  len;
  logic [ACC_W-1:0]  bias;
  logic              busy;
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res_data;

  modport master (
    output start, len, bias, op_valid, op_a, op_b, res_ready,
    input  busy, op_ready, res_valid, res_data
  );

  modport slave (
    input  start, len, bias, op_valid, op_a, op_b, res_ready,
    output busy, op_ready, res_valid, res_data
  );

endinterface

// File: rtl/mac_dot_seq_mac.sv
// Signed multiply-accumulate datapath: y = a*b + c, wrapping at 2*DATA_W bits.
module mac #(
  parameter  int DATA_W = 8,
  localparam int ACC_W  = 2 * DATA_W
) (
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  input  logic signed [ACC_W-1:0]  c_i,
  output logic signed [ACC_W-1:0]  y_o
);

  assign y_o = ACC_W'(a_i) * ACC_W'(b_i) + c_i;

endmodule

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer around one mac; result = bias + sum(op_a*op_b).
// Define DOT_SAT_EN to clamp each accumulate instead of wrapping.
module mac_dot_seq
  import mac_dot_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  mac_dot_seq_if.slave io
);

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] accNext;
  logic signed [ACC_W-1:0] macY;
  logic [LEN_W-1:0]        cnt_q, cnt_d;
  logic                    accept;

  assign accept = io.op_valid && (state_q == RUN);

  mac #(.DATA_W(DATA_W)) uMac (
    .a_i ($signed(io.op_a)),
    .b_i ($signed(io.op_b)),
    .c_i (acc_q),
    .y_o (macY)
  );

`ifdef DOT_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W-1:0] prodFull;
  logic signed [ACC_W:0]   sumWide;

  assign prodFull = ACC_W'($signed(io.op_a)) * ACC_W'($signed(io.op_b));
  assign sumWide  = (ACC_W+1)'(prodFull) + (ACC_W+1)'(acc_q);

  // The two top bits of the widened sum disagree exactly when ACC_W overflowed.
  always_comb begin
    accNext = sumWide[ACC_W-1:0];
    if (sumWide[ACC_W] != sumWide[ACC_W-1]) begin
      accNext = sumWide[ACC_W] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  assign accNext = macY;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // A zero-length run goes straight to DONE so the bias alone is reported.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (io.start) begin
          acc_d = io.bias;
          if (io.len == '0) begin
            state_d = DONE;
          end else begin
            cnt_d   = io.len;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (accept) begin
          acc_d = accNext;
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (io.res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    io.busy      = (state_q != IDLE);
    io.op_ready  = (state_q == RUN);
    io.res_valid = (state_q == DONE);
    io.res_data  = acc_q;
  end

endmodule
